// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - two-requester round-robin arbiter sharing one 8x8 unsigned multiplier
// Optional feature: define MULT_SHARE_ARB_PIPE_EN to add register stage S1b after the multiplier.
module mult_share_arb #(
  parameter int OPW = 8,
  parameter int PW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_a,
  input  logic [OPW-1:0] req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_a,
  input  logic [OPW-1:0] req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [PW-1:0]  rsp_p,
  input  logic           rsp_ready,
  output logic           busy
);

  // Advance enables for each stage
  logic adv1;
  logic adv2;

  // Arbitration
  logic grant0;
  logic grant1;
  logic ptr_q;
  logic ptr_d;

  // Stage S1: registered operands and requester id
  logic           s1_v_q;
  logic           s1_v_d;
  logic [OPW-1:0] a_q;
  logic [OPW-1:0] a_d;
  logic [OPW-1:0] b_q;
  logic [OPW-1:0] b_d;
  logic           id_q;
  logic           id_d;

  // Combinational multiplier output
  logic [PW-1:0]  prod;

  // Stage S2: response register
  logic           rsp_valid_q;
  logic           rsp_valid_d;
  logic           rsp_id_q;
  logic           rsp_id_d;
  logic [PW-1:0]  rsp_p_q;
  logic [PW-1:0]  rsp_p_d;

`ifdef MULT_SHARE_ARB_PIPE_EN
  // Stage S1b: registered product and id, breaking the multiplier path
  logic           adv1b;
  logic           s1b_v_q;
  logic           s1b_v_d;
  logic           s1b_id_q;
  logic           s1b_id_d;
  logic [PW-1:0]  s1b_p_q;
  logic [PW-1:0]  s1b_p_d;
`endif

  // Advance chain: a stage may load when it is empty or its successor moves
  always_comb begin
    adv2 = !rsp_valid_q || rsp_ready;
`ifdef MULT_SHARE_ARB_PIPE_EN
    adv1b = !s1b_v_q || adv2;
    adv1  = !s1_v_q || adv1b;
`else
    adv1  = !s1_v_q || adv2;
`endif
  end

  // Round-robin grant: lone requester wins, pointer breaks ties; nothing during reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && adv1) begin
      if (req0_valid && req1_valid) begin
        grant0 = !ptr_q;
        grant1 = ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Pointer moves to the other requester after each transfer
  always_comb begin
    ptr_d = ptr_q;
    if (req0_valid && grant0) begin
      ptr_d = 1'b1;
    end else if (req1_valid && grant1) begin
      ptr_d = 1'b0;
    end
  end

  // S1 load: capture the granted operands whenever S1 is free to advance
  always_comb begin
    s1_v_d = s1_v_q;
    a_d    = a_q;
    b_d    = b_q;
    id_d   = id_q;
    if (adv1) begin
      s1_v_d = (req0_valid && grant0) || (req1_valid && grant1);
      if (grant1) begin
        a_d  = req1_a;
        b_d  = req1_b;
        id_d = 1'b1;
      end else if (grant0) begin
        a_d  = req0_a;
        b_d  = req0_b;
        id_d = 1'b0;
      end
    end
  end

  // Array multiplier: sum of a_q shifted by each set bit of b_q
  always_comb begin
    prod = '0;
    for (int i = 0; i < OPW; i++) begin
      if (b_q[i]) begin
        prod = prod + (PW'(a_q) << i);
      end
    end
  end

`ifdef MULT_SHARE_ARB_PIPE_EN
  // S1b load: register the product so S2 sees a flop-to-flop path
  always_comb begin
    s1b_v_d  = s1b_v_q;
    s1b_id_d = s1b_id_q;
    s1b_p_d  = s1b_p_q;
    if (adv1b) begin
      s1b_v_d  = s1_v_q;
      s1b_id_d = id_q;
      s1b_p_d  = prod;
    end
  end
`endif

  // S2 load: response register holds while the consumer stalls
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    if (adv2) begin
`ifdef MULT_SHARE_ARB_PIPE_EN
      rsp_valid_d = s1b_v_q;
      rsp_id_d    = s1b_id_q;
      rsp_p_d     = s1b_p_q;
`else
      rsp_valid_d = s1_v_q;
      rsp_id_d    = id_q;
      rsp_p_d     = prod;
`endif
    end
  end

  // State registers; reset drops every in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      s1_v_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_p_q     <= '0;
`ifdef MULT_SHARE_ARB_PIPE_EN
      s1b_v_q     <= 1'b0;
      s1b_id_q    <= 1'b0;
      s1b_p_q     <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      s1_v_q      <= s1_v_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
`ifdef MULT_SHARE_ARB_PIPE_EN
      s1b_v_q     <= s1b_v_d;
      s1b_id_q    <= s1b_id_d;
      s1b_p_q     <= s1b_p_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;

`ifdef MULT_SHARE_ARB_PIPE_EN
  assign busy = s1_v_q || s1b_v_q || rsp_valid_q;
`else
  assign busy = s1_v_q || rsp_valid_q;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - scoreboard bench for mult_share_arb
module tb_mult_share_arb;

`ifdef MULT_SHARE_ARB_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_p;
  logic        rsp_ready;
  logic        busy;

  mult_share_arb #(.OPW(8), .PW(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    logic        id;
    logic [15:0] p;
    int          cyc;
    int          st;
  } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   stalls = 0;
  logic took0 = 1'b0;
  logic took1 = 1'b0;
  logic fav   = 1'b0;
  logic prev_rst  = 1'b0;
  logic prev_hold = 1'b0;
  logic        held_id;
  logic [15:0] held_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requester drivers: present the head of each queue until it is taken
  initial begin
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    forever begin
      @(posedge clk);
      #1;
      if (took0 && q0.size() > 0) void'(q0.pop_front());
      if (took1 && q1.size() > 0) void'(q1.pop_front());
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; end
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; end
    end
  end

  // Reference model and monitor, evaluated mid-cycle when all signals are settled
  always @(negedge clk) begin
    int   inflight;
    logic full;
    logic exp0;
    logic exp1;
    exp_t e;
    took0 = 1'b0;
    took1 = 1'b0;
    if (prev_rst) begin
      chk("post_reset_rsp_valid", rsp_valid, 0);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_rsp_p", rsp_p, 0);
      chk("post_reset_rsp_id", rsp_id, 0);
    end else if (prev_hold) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_p", rsp_p, held_p);
      chk("hold_id", rsp_id, held_id);
    end
    if (rst) begin
      chk("reset_ready0", req0_ready, 0);
      chk("reset_ready1", req1_ready, 0);
      sb.delete();
      fav = 1'b0;
      prev_hold = 1'b0;
    end else begin
      inflight = sb.size();
      chk("busy", busy, (inflight != 0) ? 1 : 0);
      full = (inflight == LAT) && !rsp_ready;
      exp0 = !full && req0_valid && (!req1_valid || fav == 1'b0);
      exp1 = !full && req1_valid && (!req0_valid || fav == 1'b1);
      chk("ready0", req0_ready, exp0);
      chk("ready1", req1_ready, exp1);
      if (!rsp_ready) stalls++;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_p", rsp_p, e.p);
          chk("rsp_id", rsp_id, e.id);
          if (e.st == stalls) chk("latency", cyc - e.cyc, LAT);
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      held_p = rsp_p;
      held_id = rsp_id;
      if (req0_valid && req0_ready) begin
        e.id = 1'b0; e.p = 16'(req0_a * req0_b); e.cyc = cyc; e.st = stalls;
        sb.push_back(e);
        took0 = 1'b1;
        fav = 1'b1;
      end else if (req1_valid && req1_ready) begin
        e.id = 1'b1; e.p = 16'(req1_a * req1_b); e.cyc = cyc; e.st = stalls;
        sb.push_back(e);
        took1 = 1'b1;
        fav = 1'b0;
      end
    end
    prev_rst = rst;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push0(input int a, input int b);
    op_t o;
    o.a = 8'(a); o.b = 8'(b);
    q0.push_back(o);
  endtask

  task automatic push1(input int a, input int b);
    op_t o;
    o.a = 8'(a); o.b = 8'(b);
    q1.push_back(o);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < max_cyc) begin
      step(1);
      n++;
    end
    chk("drain_left", q0.size() + q1.size() + sb.size(), 0);
  endtask

  function automatic int rnd_op();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 0;
    if (r == 1) return 255;
    return int'($urandom_range(0, 255));
  endfunction

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);

    // single requester back-to-back stream
    push0(1, 9); push0(5, 10); push0(6, 3); push0(38, 3); push0(36, 55);
    wait_drain(40);

    // contention right after reset: grants must start at requester 0
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push0(255, 255);
      push1(2, 3);
    end
    wait_drain(60);

    // backpressure with two pending requests from requester 1
    rsp_ready = 1'b0;
    push1(7, 8); push1(9, 9);
    step(7);
    rsp_ready = 1'b1;
    wait_drain(40);

    // reset with the pipeline full
    rsp_ready = 1'b0;
    push0(11, 12); push0(13, 14); push0(15, 16);
    push1(17, 18); push1(19, 20); push1(21, 22);
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    wait_drain(60);

    // randomized traffic with random consumer stalls
    for (int i = 0; i < 500; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 1) == 1) push0(rnd_op(), rnd_op());
      if (q1.size() < 3 && $urandom_range(0, 1) == 1) push1(rnd_op(), rnd_op());
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    rsp_ready = 1'b1;
    wait_drain(100);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
